instr_cache: RTL
================

# instr_cache

Direct-mapped, read-only instruction cache between the CPU fetch port (PC_OUT / INSTRUCTION) and a slow, block-oriented instruction memory. On a hit it returns the 32-bit instruction in the same cycle. On a miss it stalls the CPU with BUSYWAIT, refills one 16-byte block from memory, then serves the instruction. It replaces the zero-wait combinational instruction fetch.

## Interface
Parameters:
- ADDR_W, 10, byte-address width used from PC (1 KB instruction space)
- NUM_BLOCKS, 8, cache lines; fixed at 8 for this revision (index 3 bits)

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- RESET  input  1  asynchronous, active-low reset
- PC  input  32  byte address of the instruction to fetch; bits [1:0] ignored, bits [31:10] ignored
- INSTRUCTION  output  32  fetched instruction, big-endian byte order (byte at lowest address in bits [31:24])
- BUSYWAIT  output  1  high while a miss is outstanding; CPU must hold PC and freeze its PC update
- MEM_READ  output  1  block read request to instruction memory
- MEM_ADDRESS  output  6  block address = PC[9:4]
- MEM_READDATA  input  128  refill block; word 0 in bits [31:0], word 3 in bits [127:96]
- MEM_BUSYWAIT  input  1  memory busy; data valid in the cycle it falls after MEM_READ

## Operation
- Address split: tag = PC[9:7], index = PC[6:4], word offset = PC[3:2].
- Per line: valid bit, 3-bit tag, 128-bit data.
- Hit = valid[index] and tag[index] == PC[9:7], evaluated combinationally from PC.
- Word select: offset 0 → data[31:0] … offset 3 → data[127:96].
- FSM states:
  - IDLE: BUSYWAIT = hit ? 0 : 1. On a miss, go to MEM_RD at the next edge and latch the block address PC[9:4].
  - MEM_RD: MEM_READ = 1, MEM_ADDRESS = latched address, BUSYWAIT = 1. Stay while MEM_BUSYWAIT = 1. Go to UPDATE at the first edge where MEM_BUSYWAIT = 0 and MEM_READ has been high ≥1 cycle.
  - UPDATE: MEM_READ = 0, BUSYWAIT = 1. At the edge, write data, tag and valid = 1 into the line at the latched index, then return to IDLE.
- After UPDATE, IDLE re-evaluates PC. That access is a hit, so BUSYWAIT falls.
- PC changes while BUSYWAIT = 1 are a CPU protocol violation. The refill still completes for the latched address, and the new PC is then evaluated normally.
- Conflict miss: same index, different tag. The refill overwrites the line; no writeback because the cache is read-only.
- INSTRUCTION on a miss holds its previous value until the hit is served. It is never X after reset.

## Timing
- Reset (RESET = 0, asynchronous) forces:
  - all valid bits = 0
  - FSM = IDLE, latched address = 0
  - MEM_READ = 0, MEM_ADDRESS = 0
  - INSTRUCTION = 0
  - BUSYWAIT = 0 while reset is asserted
- Reset deassertion is sampled at the next rising CLK.
- Reset asserted mid-refill aborts the refill: no line is written and MEM_READ drops immediately.
- Hit latency: 0 cycles, combinational from PC. INSTRUCTION is registered-stable by the next edge.
- Miss penalty: 1 (IDLE→MEM_RD) + N (memory busy cycles) + 1 (UPDATE) cycles. BUSYWAIT is high for that whole span.
- Example: with memory busy for 4 cycles after request, the miss penalty is 6 cycles.
- MEM_ADDRESS is stable for the entire MEM_READ assertion. MEM_READDATA is sampled only on the MEM_RD→UPDATE edge.
- BUSYWAIT rises combinationally in the cycle the missing PC appears, so the CPU stalls before its next edge.

## Test plan
- Cold start: reset low 2 cycles, release, PC = 0 → BUSYWAIT = 1, MEM_READ = 1 with MEM_ADDRESS = 0. With memory busy 4 cycles, returning block 0x44332211_88776655_CCBBAA99_00FFEEDD, INSTRUCTION = 0x00FFEEDD. BUSYWAIT falls 6 cycles after the miss.
- Sequential hits: after the above, PC = 4, 8, 12 → BUSYWAIT stays 0, MEM_READ stays 0, INSTRUCTION = 0xCCBBAA99, 0x88776655, 0x44332211, each in the same cycle.
- Conflict miss: PC = 0x080 (index 0, tag 1) → refill with MEM_ADDRESS = 0x08. A subsequent PC = 0 misses again with MEM_ADDRESS = 0x00.
- Independent lines: fill PC = 0x010 and PC = 0x020, then alternate them → no further MEM_READ; correct words returned.
- Reset mid-refill: assert RESET during MEM_RD → MEM_READ = 0 and BUSYWAIT = 0 immediately. After release, PC = 0 misses again (valid cleared).
- Zero-wait memory: MEM_BUSYWAIT = 0 throughout → miss penalty is exactly 2 cycles after MEM_READ rises. Data is latched correctly.

Source files
------------

// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache: combinational hit path, stalls the
// fetch port with BUSYWAIT while a 16-byte block is refilled from instruction memory.
module instr_cache #(
    parameter int ADDR_W     = 10,
    parameter int NUM_BLOCKS = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [31:0]         PC,
    output logic [31:0]         INSTRUCTION,
    output logic                BUSYWAIT,
    output logic                MEM_READ,
    output logic [ADDR_W-5:0]   MEM_ADDRESS,
    input  logic [127:0]        MEM_READDATA,
    input  logic                MEM_BUSYWAIT
);

    localparam int IDX_W = $clog2(NUM_BLOCKS);
    localparam int BLK_W = ADDR_W - 4;
    localparam int TAG_W = BLK_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEM_RD = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [BLK_W-1:0]       blk_addr_reg;
    logic                   mem_read_reg;
    logic [31:0]            instr_reg;
    logic [127:0]           fill_reg;
    logic [NUM_BLOCKS-1:0]  valid_reg;
    logic [TAG_W-1:0]       tag_reg  [NUM_BLOCKS];
    logic [127:0]           data_reg [NUM_BLOCKS];

    logic [TAG_W-1:0]       pc_tag;
    logic [IDX_W-1:0]       pc_idx;
    logic [1:0]             pc_off;
    logic                   hit;
    logic [31:0]            line_words [4];
    logic [31:0]            hit_word;
    logic [TAG_W-1:0]       fill_tag;
    logic [IDX_W-1:0]       fill_idx;
    logic                   pc_unused;

    assign pc_tag    = PC[ADDR_W-1 -: TAG_W];
    assign pc_idx    = PC[4 +: IDX_W];
    assign pc_off    = PC[3:2];
    assign pc_unused = ^{PC[31:ADDR_W], PC[1:0]};

    assign fill_tag  = blk_addr_reg[BLK_W-1 -: TAG_W];
    assign fill_idx  = blk_addr_reg[IDX_W-1:0];

    assign hit = valid_reg[pc_idx] && (tag_reg[pc_idx] == pc_tag);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_word
            assign line_words[gi] = data_reg[pc_idx][gi*32 +: 32];
        end
    endgenerate

    assign hit_word = line_words[pc_off];

    // Only an idle-state hit is served; otherwise the last served word is held.
    assign INSTRUCTION = (state_reg == IDLE && hit) ? hit_word : instr_reg;
    assign BUSYWAIT    = RESET && ((state_reg != IDLE) || !hit);
    assign MEM_READ    = mem_read_reg;
    assign MEM_ADDRESS = blk_addr_reg;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg    <= IDLE;
            blk_addr_reg <= '0;
            mem_read_reg <= 1'b0;
            instr_reg    <= '0;
            valid_reg    <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (hit) begin
                        instr_reg <= hit_word;
                    end else begin
                        blk_addr_reg <= PC[ADDR_W-1:4];
                        mem_read_reg <= 1'b1;
                        state_reg    <= MEM_RD;
                    end
                end
                MEM_RD: begin
                    if (!MEM_BUSYWAIT) begin
                        mem_read_reg <= 1'b0;
                        state_reg    <= UPDATE;
                    end
                end
                UPDATE: begin
                    valid_reg[fill_idx] <= 1'b1;
                    state_reg           <= IDLE;
                end
                default: begin
                    mem_read_reg <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    // Block buffer and line storage need no reset: valid_reg gates every use.
    always_ff @(posedge CLK) begin
        if (state_reg == MEM_RD && !MEM_BUSYWAIT) begin
            fill_reg <= MEM_READDATA;
        end
        if (state_reg == UPDATE) begin
            tag_reg[fill_idx]  <= fill_tag;
            data_reg[fill_idx] <= fill_reg;
        end
    end

endmodule
